// File: rtl/ucode_offset_sequencer_pkg.sv
// Shared types and width helpers for the uCode row-offset sequencer.
// Types here are sized for the default 32-row / 4-channel configuration.
package pkg_ucode_sequencer;

  localparam int unsigned DEF_ROWS_PER_HDVECT = 32;
  localparam int unsigned DEF_NUM_CHANNELS    = 4;

  function automatic int unsigned offset_width(input int unsigned rows);
    return $clog2(rows);
  endfunction

  function automatic int unsigned ch_width(input int unsigned chans);
    return (chans <= 1) ? 1 : $clog2(chans);
  endfunction

  localparam int unsigned DEF_OFFSET_W = offset_width(DEF_ROWS_PER_HDVECT);
  localparam int unsigned DEF_LEN_W    = offset_width(DEF_ROWS_PER_HDVECT + 1);
  localparam int unsigned DEF_CH_W     = ch_width(DEF_NUM_CHANNELS);

  typedef logic [DEF_OFFSET_W-1:0] offset_t;
  typedef logic [DEF_LEN_W-1:0]    len_t;
  typedef logic [DEF_CH_W-1:0]     channel_t;

  typedef struct packed {
    offset_t  offset;
    len_t     len;
    offset_t  stride;
    channel_t channel;
    logic     reverse;
  } ucode_offs_cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ucode_offs_state_e;

endpackage

// File: rtl/ucode_offset_wrap_add.sv
// Combinational add/subtract of two row offsets, wrapped into [0, ROWS).
// Operands must already be < ROWS, so one correction step is enough.
module ucode_offset_wrap_add
  import pkg_ucode_sequencer::*;
#(
  parameter  int unsigned ROWS = 32,
  localparam int unsigned W    = offset_width(ROWS)
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] y_o
);

  localparam logic [W:0] ROWS_V = (W+1)'(ROWS);

  logic [W:0] sum;
  logic [W:0] diff;

  // One extra bit catches both the overflow past ROWS and the borrow below 0.
  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i};
    diff = {1'b0, a_i} - {1'b0, b_i};
    if (sub_i) begin
      y_o = diff[W] ? W'(diff + ROWS_V) : diff[W-1:0];
    end else begin
      y_o = (sum >= ROWS_V) ? W'(sum - ROWS_V) : sum[W-1:0];
    end
  end

endmodule

// File: rtl/ucode_offset_sequencer.sv
// Streams a strided, wrapped walk of row offsets for one command at a time.
// Downward walks are available when UCODE_SEQ_REVERSE_EN is defined.
module ucode_offset_sequencer
  import pkg_ucode_sequencer::*;
#(
  parameter  int unsigned ROWS_PER_HDVECT = 32,
  parameter  int unsigned NUM_CHANNELS    = 4,
  localparam int unsigned OFFSET_W        = offset_width(ROWS_PER_HDVECT),
  localparam int unsigned LEN_W           = offset_width(ROWS_PER_HDVECT + 1),
  localparam int unsigned CH_W            = ch_width(NUM_CHANNELS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [OFFSET_W-1:0] cmd_offset_i,
  input  logic [LEN_W-1:0]    cmd_len_i,
  input  logic [OFFSET_W-1:0] cmd_stride_i,
  input  logic [CH_W-1:0]     cmd_channel_i,
  input  logic                cmd_reverse_i,
  output logic                offs_valid_o,
  input  logic                offs_ready_i,
  output logic [OFFSET_W-1:0] offs_o,
  output logic [CH_W-1:0]     offs_channel_o,
  output logic                offs_last_o,
  output logic                busy_o
);

  typedef logic [OFFSET_W-1:0] row_t;
  typedef logic [LEN_W-1:0]    cnt_t;
  typedef logic [CH_W-1:0]     chan_t;

  // offset holds the current beat and len the beats still to send.
  typedef struct packed {
    row_t  offset;
    cnt_t  len;
    row_t  stride;
    chan_t channel;
    logic  reverse;
  } seq_cmd_t;

  ucode_offs_state_e state_q, state_d;
  seq_cmd_t          cmd_q, cmd_d;
  row_t              next_offs;
  logic              reverse_in;

`ifdef UCODE_SEQ_REVERSE_EN
  assign reverse_in = cmd_reverse_i;
`else
  logic unused_reverse;
  assign unused_reverse = cmd_reverse_i;
  assign reverse_in     = 1'b0;
`endif

  ucode_offset_wrap_add #(
    .ROWS (ROWS_PER_HDVECT)
  ) u_wrap_add (
    .a_i   (cmd_q.offset),
    .b_i   (cmd_q.stride),
    .sub_i (cmd_q.reverse),
    .y_o   (next_offs)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  // Clear overrides any handshake decided above it in the same cycle.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cmd_ready_o  = 1'b0;
    offs_valid_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i && (cmd_len_i != '0)) begin
          cmd_d.offset  = cmd_offset_i;
          cmd_d.len     = cmd_len_i;
          cmd_d.stride  = cmd_stride_i;
          cmd_d.channel = cmd_channel_i;
          cmd_d.reverse = reverse_in;
          state_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        offs_valid_o = 1'b1;
        if (offs_ready_i) begin
          cmd_d.offset = next_offs;
          cmd_d.len    = cmd_q.len - LEN_W'(1);
          if (cmd_q.len == LEN_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) begin
      state_d = ST_IDLE;
    end
  end

  assign offs_o         = cmd_q.offset;
  assign offs_channel_o = cmd_q.channel;
  assign offs_last_o    = (state_q == ST_RUN) && (cmd_q.len == LEN_W'(1));
  assign busy_o         = (state_q == ST_RUN);

  a_cmd_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    (cmd_valid_i && cmd_ready_o && !clear_i) |->
      (({1'b0, cmd_offset_i} < (OFFSET_W+1)'(ROWS_PER_HDVECT)) &&
       ({1'b0, cmd_stride_i} < (OFFSET_W+1)'(ROWS_PER_HDVECT)) &&
       ((OFFSET_W+1)'(cmd_len_i) <= (OFFSET_W+1)'(ROWS_PER_HDVECT)) &&
       ({1'b0, cmd_channel_i} < (CH_W+1)'(NUM_CHANNELS))));

endmodule

// File: tb/tb_ucode_offset_sequencer.sv
// Self-checking bench: a beat-list model of each accepted command is compared
// every cycle against the DUT, plus directed walks with literal beat lists.
module tb_ucode_offset_sequencer;

  localparam int ROWS = 32;
  localparam int OW   = 5;
  localparam int LW   = 6;
  localparam int CW   = 2;
  localparam int R24  = 24;
  localparam int LW24 = 5;

  typedef struct {
    int offs;
    int ch;
    int last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic cmdValid = 1'b0;
  logic cmdReady;
  logic [OW-1:0] cmdOffset = '0;
  logic [LW-1:0] cmdLen = '0;
  logic [OW-1:0] cmdStride = '0;
  logic [CW-1:0] cmdChannel = '0;
  logic cmdReverse = 1'b0;
  logic offsValid;
  logic offsReady = 1'b0;
  logic [OW-1:0] offs;
  logic [CW-1:0] offsChannel;
  logic offsLast;
  logic busy;

  logic c24Valid = 1'b0;
  logic c24Ready;
  logic [OW-1:0] c24Offset = '0;
  logic [LW24-1:0] c24Len = '0;
  logic [OW-1:0] c24Stride = '0;
  logic v24;
  logic [OW-1:0] o24;
  logic [CW-1:0] ch24;
  logic last24;
  logic busy24;

  int nChecks = 0;
  int nPass = 0;
  bit checkEn = 1'b0;
  beat_t expQ[$];
  int obsOffs[$];
  int obsLast[$];
  int log24Offs[$];
  int log24Last[$];

  ucode_offset_sequencer #(.ROWS_PER_HDVECT(ROWS), .NUM_CHANNELS(4)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady),
    .cmd_offset_i(cmdOffset), .cmd_len_i(cmdLen), .cmd_stride_i(cmdStride),
    .cmd_channel_i(cmdChannel), .cmd_reverse_i(cmdReverse),
    .offs_valid_o(offsValid), .offs_ready_i(offsReady), .offs_o(offs),
    .offs_channel_o(offsChannel), .offs_last_o(offsLast), .busy_o(busy)
  );

  ucode_offset_sequencer #(.ROWS_PER_HDVECT(R24), .NUM_CHANNELS(4)) dut24 (
    .clk_i(clk), .rst_i(rst), .clear_i(1'b0),
    .cmd_valid_i(c24Valid), .cmd_ready_o(c24Ready),
    .cmd_offset_i(c24Offset), .cmd_len_i(c24Len), .cmd_stride_i(c24Stride),
    .cmd_channel_i(2'd1), .cmd_reverse_i(1'b0),
    .offs_valid_o(v24), .offs_ready_i(1'b1), .offs_o(o24),
    .offs_channel_o(ch24), .offs_last_o(last24), .busy_o(busy24)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual == expected) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Model: an accepted command becomes its whole beat list up front.
  always @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      expQ.delete();
    end else if (expQ.size() > 0) begin
      if (offsReady) void'(expQ.pop_front());
    end else if (cmdValid && cmdLen != 0) begin
      int len, o, s, rev;
      len = int'(cmdLen);
      o = int'(cmdOffset);
      s = int'(cmdStride);
`ifdef UCODE_SEQ_REVERSE_EN
      rev = int'(cmdReverse);
`else
      rev = 0;
`endif
      for (int i = 0; i < len; i++) begin
        beat_t b;
        if (rev != 0) b.offs = (((o - i * s) % ROWS) + ROWS) % ROWS;
        else b.offs = (o + i * s) % ROWS;
        b.ch = int'(cmdChannel);
        b.last = (i == len - 1) ? 1 : 0;
        expQ.push_back(b);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && checkEn) begin
      checkOutput("valid", int'(offsValid), (expQ.size() > 0) ? 1 : 0);
      checkOutput("cmdReady", int'(cmdReady), (expQ.size() == 0) ? 1 : 0);
      checkOutput("busy", int'(busy), (expQ.size() > 0) ? 1 : 0);
      if (expQ.size() > 0) begin
        checkOutput("offs", int'(offs), expQ[0].offs);
        checkOutput("channel", int'(offsChannel), expQ[0].ch);
        checkOutput("last", int'(offsLast), expQ[0].last);
      end
    end
    if (!rst && offsValid && offsReady && !clear) begin
      obsOffs.push_back(int'(offs));
      obsLast.push_back(int'(offsLast));
    end
    if (!rst && v24) begin
      log24Offs.push_back(int'(o24));
      log24Last.push_back(int'(last24));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int off, input int len, input int stride,
                               input int ch, input int rev);
    cmdOffset = OW'(off);
    cmdLen = LW'(len);
    cmdStride = OW'(stride);
    cmdChannel = CW'(ch);
    cmdReverse = rev[0];
    cmdValid = 1'b1;
    tick();
    cmdValid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (!(expQ.size() == 0 && cmdReady) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("idle within budget", (n < budget) ? 1 : 0, 1);
  endtask

  task automatic runLiteral(input string name, input int off, input int len, input int stride,
                            input int ch, input int rev, input int expOffs[$]);
    obsOffs.delete();
    obsLast.delete();
    offsReady = 1'b1;
    applyStimulus(off, len, stride, ch, rev);
    checkOutput({name, " model len"}, expQ.size(), expOffs.size());
    foreach (expOffs[i]) if (i < expQ.size()) checkOutput({name, " model offs"}, expQ[i].offs, expOffs[i]);
    waitIdle(100);
    checkOutput({name, " beats"}, obsOffs.size(), expOffs.size());
    foreach (expOffs[i]) begin
      if (i < obsOffs.size()) begin
        checkOutput({name, " offs"}, obsOffs[i], expOffs[i]);
        checkOutput({name, " last"}, obsLast[i], (i == expOffs.size() - 1) ? 1 : 0);
      end
    end
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, " valid"}, int'(offsValid), 0);
    checkOutput({name, " cmdReady"}, int'(cmdReady), 1);
    checkOutput({name, " busy"}, int'(busy), 0);
    checkOutput({name, " offs"}, int'(offs), 0);
    checkOutput({name, " channel"}, int'(offsChannel), 0);
    checkOutput({name, " last"}, int'(offsLast), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 checkResetValues("reset");
    tick();
    tick();
    rst = 1'b0;
    checkEn = 1'b1;
    tick();

    runLiteral("wrap32", 30, 4, 1, 2, 0, '{30, 31, 0, 1});
    runLiteral("stride0", 9, 3, 0, 3, 0, '{9, 9, 9});
`ifdef UCODE_SEQ_REVERSE_EN
    runLiteral("reverse", 1, 3, 2, 1, 1, '{1, 31, 29});
`else
    runLiteral("reverse", 1, 3, 2, 1, 1, '{1, 3, 5});
`endif

    // Stall on the second beat for five cycles.
    obsOffs.delete();
    obsLast.delete();
    offsReady = 1'b1;
    applyStimulus(0, 3, 2, 0, 0);
    tick();
    offsReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall offs", int'(offs), 2);
      checkOutput("stall valid", int'(offsValid), 1);
      tick();
    end
    offsReady = 1'b1;
    waitIdle(50);
    checkOutput("stall beats", obsOffs.size(), 3);
    if (obsOffs.size() == 3) checkOutput("stall third", obsOffs[2], 4);

    // Clear on beat 2 of an 8-beat walk, with a competing command.
    obsOffs.delete();
    applyStimulus(3, 8, 1, 2, 0);
    tick();
    clear = 1'b1;
    cmdValid = 1'b1;
    cmdOffset = OW'(9);
    cmdLen = LW'(2);
    tick();
    clear = 1'b0;
    cmdValid = 1'b0;
    checkOutput("clear valid", int'(offsValid), 0);
    checkOutput("clear cmdReady", int'(cmdReady), 1);
    tick();
    checkOutput("clear no new cmd", int'(offsValid), 0);
    checkOutput("clear beats", obsOffs.size(), 1);

    // Clear in IDLE also blocks a command.
    clear = 1'b1;
    cmdValid = 1'b1;
    tick();
    clear = 1'b0;
    cmdValid = 1'b0;
    checkOutput("idle clear valid", int'(offsValid), 0);

    applyStimulus(5, 0, 1, 0, 0);
    checkOutput("len0 valid", int'(offsValid), 0);
    checkOutput("len0 cmdReady", int'(cmdReady), 1);
    runLiteral("len1", 7, 1, 3, 1, 0, '{7});

    // Full coverage walk: stride 5 is coprime to 32.
    obsOffs.delete();
    applyStimulus(4, 32, 5, 0, 0);
    waitIdle(100);
    begin
      bit seen[ROWS];
      int distinct = 0;
      foreach (obsOffs[i]) if (obsOffs[i] >= 0 && obsOffs[i] < ROWS && !seen[obsOffs[i]]) begin
        seen[obsOffs[i]] = 1'b1;
        distinct++;
      end
      checkOutput("full walk distinct rows", distinct, ROWS);
    end

    // Non power-of-two row count.
    c24Offset = OW'(20);
    c24Len = LW24'(3);
    c24Stride = OW'(5);
    c24Valid = 1'b1;
    tick();
    c24Valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checkOutput("rows24 beats", log24Offs.size(), 3);
    if (log24Offs.size() == 3) begin
      checkOutput("rows24 b0", log24Offs[0], 20);
      checkOutput("rows24 b1", log24Offs[1], 1);
      checkOutput("rows24 b2", log24Offs[2], 6);
      checkOutput("rows24 last", log24Last[2], 1);
      checkOutput("rows24 not last", log24Last[1], 0);
    end

    // Reset in the middle of a walk.
    applyStimulus(10, 8, 3, 1, 0);
    tick();
    tick();
    rst = 1'b1;
    #2 checkResetValues("midwalk reset");
    #1 rst = 1'b0;
    tick();

    // Randomized commands with random backpressure and rare clears.
    for (int n = 0; n < 80; n++) begin
      int len;
      waitIdle(100);
      len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, ROWS);
      offsReady = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, ROWS - 1), len, $urandom_range(0, ROWS - 1),
                    $urandom_range(0, 3), $urandom_range(0, 1));
      for (int c = 0; c < 400 && expQ.size() > 0; c++) begin
        offsReady = ($urandom_range(0, 3) != 0);
        clear = ($urandom_range(0, 49) == 0);
        tick();
      end
      clear = 1'b0;
    end
    waitIdle(100);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
